// File: rtl/bus_mem_responder_if.sv
// Tagged processor/memory bus: command side (proc2mem) and tagged response side (mem2proc).
interface bus_mem_responder_if;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  modport master (
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the tagged bus: 64-bit word store plus in-order outstanding-load tracker.
// Optional MEM_RAND_REJECT_EN adds an LFSR that rejects commands pseudo-randomly.
module bus_mem_responder #(
  parameter int unsigned LATENCY         = 4,
  parameter int unsigned MEM_WORDS       = 8192,
  parameter int unsigned MAX_OUTSTANDING = 15
) (
  input  logic               clock,
  input  logic               reset,
  bus_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;
  localparam logic [3:0]  PTR_LAST = 4'(MAX_OUTSTANDING - 1);

  logic [63:0] mem_q [MEM_WORDS];

  logic [MAX_OUTSTANDING:1] busy_q, busy_d;
  logic [3:0]  slot_tag_q  [MAX_OUTSTANDING], slot_tag_d  [MAX_OUTSTANDING];
  logic [63:0] slot_data_q [MAX_OUTSTANDING], slot_data_d [MAX_OUTSTANDING];
  logic [3:0]  slot_cnt_q  [MAX_OUTSTANDING], slot_cnt_d  [MAX_OUTSTANDING];
  logic [3:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
  logic [3:0]  out_tag_q, out_tag_d;
  logic [63:0] out_data_q, out_data_d;

  logic          is_load, is_store, in_range, rand_reject, accept, load_acc, store_acc;
  logic          head_ready, push, pop, unused_addr_bits;
  logic [AW-1:0] word_idx;
  logic [3:0]    grant_tag;
  logic [63:0]   rd_word;

  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == PTR_LAST) ? '0 : p + 4'd1;
  endfunction

`ifdef MEM_RAND_REJECT_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rand_reject = (lfsr_q[1:0] == 2'b00);
  end
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign rand_reject = 1'b0;
`endif

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (bus.proc2mem_command)
      BUS_LOAD:  is_load  = 1'b1;
      BUS_STORE: is_store = 1'b1;
      default:   ;
    endcase
    in_range         = bus.proc2mem_addr[63:3] < 61'(MEM_WORDS);
    word_idx         = bus.proc2mem_addr[AW+2:3];
    unused_addr_bits = ^bus.proc2mem_addr[2:0];
    rd_word          = mem_q[word_idx];

    grant_tag = '0;
    for (int unsigned i = MAX_OUTSTANDING; i >= 1; i--)
      if (!busy_q[i]) grant_tag = 4'(i);

    accept    = !reset && (is_load || is_store) && in_range && (grant_tag != '0) && !rand_reject;
    load_acc  = accept && is_load;
    store_acc = accept && is_store;
  end

  assign bus.mem2proc_response = accept ? grant_tag : '0;
  assign bus.mem2proc_tag      = out_tag_q;
  assign bus.mem2proc_data     = out_data_q;

  // Slots sit in a FIFO in accept order; only the head may return, so a finished
  // non-head slot holds at zero until everything older has gone out.
  always_comb begin
    busy_d      = busy_q;
    slot_tag_d  = slot_tag_q;
    slot_data_d = slot_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    out_tag_d   = '0;
    out_data_d  = '0;
    push        = 1'b0;
    pop         = 1'b0;
    head_ready  = (count_q != '0) && (slot_cnt_q[rd_ptr_q] == '0);

    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++)
      slot_cnt_d[i] = (slot_cnt_q[i] != '0) ? slot_cnt_q[i] - 4'd1 : '0;

    // The tag on the output this cycle is released now; grant_tag never equals it.
    for (int unsigned i = 1; i <= MAX_OUTSTANDING; i++) begin
      if (out_tag_q == 4'(i))               busy_d[i] = 1'b0;
      if (load_acc && (grant_tag == 4'(i))) busy_d[i] = 1'b1;
    end

    if (head_ready) begin
      out_tag_d  = slot_tag_q[rd_ptr_q];
      out_data_d = slot_data_q[rd_ptr_q];
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      pop        = 1'b1;
    end else if ((LATENCY == 1) && load_acc) begin
      out_tag_d  = grant_tag;
      out_data_d = rd_word;
    end

    if ((LATENCY > 1) && load_acc) begin
      slot_tag_d[wr_ptr_q]  = grant_tag;
      slot_data_d[wr_ptr_q] = rd_word;
      slot_cnt_d[wr_ptr_q]  = CNT_INIT;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
      push                  = 1'b1;
    end

    count_d = count_q + {3'b0, push} - {3'b0, pop};
  end

  always_ff @(posedge clock) begin
    if (store_acc) mem_q[word_idx] <= bus.proc2mem_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= '0;
      slot_tag_q  <= '{default: '0};
      slot_data_q <= '{default: '0};
      slot_cnt_q  <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      slot_tag_q  <= slot_tag_d;
      slot_data_q <= slot_data_d;
      slot_cnt_q  <= slot_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (LATENCY 4 and 15) driven with identical stimulus
// and checked every cycle against a queue-based reference of the bus rules.
module tb_bus_mem_responder;
  localparam int unsigned MW   = 8192;
  localparam int unsigned LAT0 = 4;
  localparam int unsigned LAT1 = 15;
  localparam logic [1:0]  CMD_NONE  = 2'd0;
  localparam logic [1:0]  CMD_LOAD  = 2'd1;
  localparam logic [1:0]  CMD_STORE = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bus_mem_responder_if bus0 ();
  bus_mem_responder_if bus1 ();

  bus_mem_responder dut0 (.clock(clock), .reset(reset), .bus(bus0));
  bus_mem_responder #(.LATENCY(LAT1), .MEM_WORDS(MW), .MAX_OUTSTANDING(15))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  typedef struct {
    int unsigned inst;
    int unsigned due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        ret_q[$];
  bit   [15:0] ref_busy [2];
  logic [63:0] ref_mem  [2][32];
  logic [15:0] ref_lfsr;
  int unsigned cyc, total, bad;
  logic [3:0]  last_resp [2];
  logic [3:0]  last_tag  [2];
  logic [63:0] last_data [2];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // One bus cycle: drive, sample at negedge, compare both instances, advance the reference.
  task automatic step(input logic rst, input logic [1:0] cmd, input logic [63:0] addr,
                      input logic [63:0] data);
    logic [3:0]  exp_resp, obs_resp, obs_tag;
    logic [63:0] obs_data;
    logic        rej;
    int          idx;
    int unsigned w;
    #1;
    reset = rst;
    bus0.proc2mem_command = cmd; bus0.proc2mem_addr = addr; bus0.proc2mem_data = data;
    bus1.proc2mem_command = cmd; bus1.proc2mem_addr = addr; bus1.proc2mem_data = data;
    @(negedge clock);
    rej = 1'b0;
`ifdef MEM_RAND_REJECT_EN
    rej = (ref_lfsr[1:0] == 2'b00);
`endif
    w = int'(addr[7:3]);
    for (int k = 0; k < 2; k++) begin
      obs_resp = (k == 0) ? bus0.mem2proc_response : bus1.mem2proc_response;
      obs_tag  = (k == 0) ? bus0.mem2proc_tag      : bus1.mem2proc_tag;
      obs_data = (k == 0) ? bus0.mem2proc_data     : bus1.mem2proc_data;
      last_resp[k] = obs_resp; last_tag[k] = obs_tag; last_data[k] = obs_data;

      exp_resp = '0;
      if (!rst && (cmd == CMD_LOAD || cmd == CMD_STORE) && (addr[63:3] < 61'(MW)) && !rej)
        for (int t = 15; t >= 1; t--)
          if (!ref_busy[k][t]) exp_resp = 4'(t);
      chk($sformatf("resp%0d", k), {60'd0, obs_resp}, {60'd0, exp_resp});

      idx = -1;
      foreach (ret_q[i]) if (idx < 0 && ret_q[i].inst == k) idx = i;
      if (idx >= 0 && ret_q[idx].due > cyc) idx = -1;
      if (idx >= 0) begin
        chk($sformatf("tag%0d", k), {60'd0, obs_tag}, {60'd0, ret_q[idx].tag});
        chk($sformatf("data%0d", k), obs_data, ret_q[idx].data);
        ref_busy[k][ret_q[idx].tag] = 1'b0;
        ret_q.delete(idx);
      end else begin
        chk($sformatf("idle_tag%0d", k), {60'd0, obs_tag}, 64'd0);
        if (rst) chk($sformatf("rst_data%0d", k), obs_data, 64'd0);
      end

      if (exp_resp != '0) begin
        if (cmd == CMD_STORE) ref_mem[k][w] = data;
        else begin
          ret_q.push_back('{inst: k, due: cyc + ((k == 0) ? LAT0 : LAT1),
                            tag: exp_resp, data: ref_mem[k][w]});
          ref_busy[k][exp_resp] = 1'b1;
        end
      end
    end
    if (rst) begin
      ret_q.delete();
      ref_busy[0] = '0; ref_busy[1] = '0;
      ref_lfsr = 16'hACE1;
    end else begin
      ref_lfsr = {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end
    cyc++;
    @(posedge clock);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, CMD_NONE, 64'd0, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  c;
    total = 0; bad = 0; cyc = 0;
    ref_busy[0] = '0; ref_busy[1] = '0;
    ref_lfsr = 16'hACE1;
    bus0.proc2mem_command = CMD_LOAD; bus0.proc2mem_addr = 64'h10; bus0.proc2mem_data = '0;
    bus1.proc2mem_command = CMD_LOAD; bus1.proc2mem_addr = 64'h10; bus1.proc2mem_data = '0;
    @(posedge clock);

    // Reset with a load pending: nothing granted, nothing ever returned.
    repeat (3) step(1'b1, CMD_LOAD, 64'h10, 64'd0);
    idle(20);

    // Preload words 0..31; retried if the random-reject LFSR refuses the store.
    for (int unsigned wd = 0; wd < 32; wd++) begin
      for (int tries = 0; tries < 8; tries++) begin
        step(1'b0, CMD_STORE, 64'(wd) << 3, {32'hDEAD_BEEF, wd});
        if (last_resp[0] != '0) break;
      end
    end
    idle(4);

    step(1'b0, CMD_LOAD, 64'h10, 64'd0);
`ifndef MEM_RAND_REJECT_EN
    chk("dir_load_resp", {60'd0, last_resp[0]}, 64'd1);
`endif
    idle(3);
    step(1'b0, CMD_NONE, 64'd0, 64'd0);
`ifndef MEM_RAND_REJECT_EN
    chk("dir_load_tag", {60'd0, last_tag[0]}, 64'd1);
    chk("dir_load_data", last_data[0], 64'hDEAD_BEEF_0000_0002);
`endif
    idle(16);

    step(1'b0, CMD_STORE, 64'h18, 64'h1234);
    step(1'b0, CMD_LOAD, 64'h1C, 64'd0);
    idle(3);
    step(1'b0, CMD_NONE, 64'd0, 64'd0);
`ifndef MEM_RAND_REJECT_EN
    chk("st_ld_fwd_data", last_data[0], 64'h1234);
`endif
    idle(16);

    // Tag exhaustion on the long-latency instance.
    for (int unsigned i = 0; i < 15; i++) begin
      step(1'b0, CMD_LOAD, 64'(i) << 3, 64'd0);
`ifndef MEM_RAND_REJECT_EN
      chk("exh_resp", {60'd0, last_resp[1]}, 64'(i + 1));
`endif
    end
    step(1'b0, CMD_LOAD, 64'h20, 64'd0);
`ifndef MEM_RAND_REJECT_EN
    chk("exh_full", {60'd0, last_resp[1]}, 64'd0);
    chk("exh_ret_tag", {60'd0, last_tag[1]}, 64'd1);
`endif
    step(1'b0, CMD_LOAD, 64'h28, 64'd0);
`ifndef MEM_RAND_REJECT_EN
    chk("exh_regrant", {60'd0, last_resp[1]}, 64'd1);
`endif
    idle(20);

    // Out-of-range accesses: rejected, and the aliasing word 0 stays intact.
    step(1'b0, CMD_LOAD, 64'(MW) * 8, 64'd0);
    chk("oor_load", {60'd0, last_resp[0]}, 64'd0);
    step(1'b0, CMD_STORE, 64'(MW) * 8, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("oor_store", {60'd0, last_resp[0]}, 64'd0);
    step(1'b0, CMD_STORE, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("oor_high", {60'd0, last_resp[1]}, 64'd0);
    step(1'b0, 2'b11, 64'h10, 64'd0);
    chk("bad_cmd", {60'd0, last_resp[0]}, 64'd0);
    step(1'b0, CMD_LOAD, 64'h0, 64'd0);
    idle(20);

    // Reset in the middle of traffic drops in-flight loads.
    repeat (3) step(1'b0, CMD_LOAD, 64'h8, 64'd0);
    repeat (2) step(1'b1, CMD_NONE, 64'd0, 64'd0);
    idle(20);

    repeat (64) step(1'b0, CMD_LOAD, 64'($urandom_range(0, 31)) << 3, 64'd0);
    idle(20);

    repeat (400) begin
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = (64'(MW) + 64'($urandom_range(0, 1000))) << 3;
      else a = (64'($urandom_range(0, 31)) << 3) | 64'($urandom_range(0, 7));
      step(1'b0, c, a, {$urandom, $urandom});
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
